// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 scan code decoder with prefix FSM, shift tracking, ASCII map and event FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  input  logic       ev_ready,
  input  logic       ov_clear,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic       ev_release,
  output logic       ev_extended,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // bit 0 is the extended flag, bit 1 the break flag
  typedef enum logic [1:0] {IDLE = 2'b00, EXT = 2'b01, BRK = 2'b10, EXT_BRK = 2'b11} state_t;

  state_t state, state_next;
  logic   shift, shift_next;
  logic   sync1, sync2, sync3;
  logic   capture, push, ext, brk;
  logic [7:0] ascii;

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0]   count, count_after_pop;
  logic          full, pop, wr_en, drop;

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic is_ext,
                                          input logic is_shift);
    logic [7:0] a;
    logic       letter;
    a = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      default: begin
        letter = 1'b0;
        case (code)
          8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
          8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
          8'h3E: a = "8";  8'h46: a = "9";
          8'h29: a = 8'h20;
          8'h5A: a = 8'h0D;
          8'h66: a = 8'h08;
          default: a = 8'h00;
        endcase
      end
    endcase
    if (letter && is_shift) a = a - 8'h20;
    // only Enter survives the E0 prefix
    if (is_ext) a = (code == 8'h5A) ? 8'h0D : 8'h00;
    return a;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      state <= IDLE;
      shift <= 1'b0;
    end else begin
      sync1 <= scan_ready;
      sync2 <= sync1;
      sync3 <= sync2;
      state <= state_next;
      shift <= shift_next;
    end
  end

  assign capture = sync2 & ~sync3;
  assign ext     = state[0];
  assign brk     = state[1];

  always_comb begin
    state_next = state;
    shift_next = shift;
    push       = 1'b0;
    if (capture) begin
      case (scan_code)
        8'hE0: state_next = state_t'({brk, 1'b1});
        8'hF0: state_next = state_t'({1'b1, ext});
        8'hE1, 8'hFA, 8'hAA: state_next = state;
        default: begin
          push       = 1'b1;
          state_next = IDLE;
          if (!ext && (scan_code == 8'h12 || scan_code == 8'h59)) shift_next = ~brk;
        end
      endcase
    end
  end

  assign ascii = brk ? 8'h00 : ascii_of(scan_code, ext, shift);

  assign full            = (count == (AW+1)'(FIFO_DEPTH));
  assign pop             = ev_valid & ev_ready;
  assign wr_en           = push & (~full | pop);
  assign drop            = push & full & ~pop;
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ext, brk, scan_code, ascii};
  end

  // head registers see the post-pop view; a push lands in them one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      ev_valid    <= 1'b0;
      ev_code     <= 8'h00;
      ev_ascii    <= 8'h00;
      ev_release  <= 1'b0;
      ev_extended <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      count <= count_after_pop + (AW+1)'(wr_en);
      if (drop) overflow <= 1'b1;
      else if (ov_clear) overflow <= 1'b0;
      ev_valid <= (count_after_pop != '0);
      if (count_after_pop != '0) begin
        {ev_extended, ev_release, ev_code, ev_ascii} <= mem[rd_next];
      end else begin
        {ev_extended, ev_release, ev_code, ev_ascii} <= 18'h0;
      end
    end
  end

endmodule
